// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU encodings,
// halt causes, FSM states and the decoded control bundle.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned ERR_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [ERR_W-1:0] ERR_OVF     = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               src1;
    logic               src2;
    logic               dest_rt;
    logic               we;
    logic               is_branch;
    logic               br_ne;
    logic               illegal;
    logic               halt;
    logic               ovf_chk;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational opcode/funct decoder producing the datapath control bundle.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]    op_i,
  input  logic [ALUOP_W-1:0] funct_i,
  output ctrl_t              ctrl_c_o
);

  always_comb begin
    ctrl_c_o        = '0;
    ctrl_c_o.alu_op = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        ctrl_c_o.alu_op  = funct_i;
        ctrl_c_o.illegal = (funct_i == 3'b110) || (funct_i == 3'b111);
        ctrl_c_o.we      = ~ctrl_c_o.illegal;
        ctrl_c_o.ovf_chk = (funct_i == ALU_ADD) || (funct_i == ALU_SUB);
      end
      OP_ADDI: begin
        ctrl_c_o.alu_op  = ALU_ADD;
        ctrl_c_o.src2    = 1'b1;
        ctrl_c_o.dest_rt = 1'b1;
        ctrl_c_o.we      = 1'b1;
        ctrl_c_o.ovf_chk = 1'b1;
      end
      OP_ANDI: begin
        ctrl_c_o.alu_op  = ALU_AND;
        ctrl_c_o.src2    = 1'b1;
        ctrl_c_o.dest_rt = 1'b1;
        ctrl_c_o.we      = 1'b1;
      end
      OP_ORI: begin
        ctrl_c_o.alu_op  = ALU_OR;
        ctrl_c_o.src2    = 1'b1;
        ctrl_c_o.dest_rt = 1'b1;
        ctrl_c_o.we      = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c_o.alu_op    = ALU_SUB;
        ctrl_c_o.is_branch = 1'b1;
      end
      OP_BNE: begin
        ctrl_c_o.alu_op    = ALU_SUB;
        ctrl_c_o.is_branch = 1'b1;
        ctrl_c_o.br_ne     = 1'b1;
      end
      OP_HALT: ctrl_c_o.halt = 1'b1;
      default: ctrl_c_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multicycle (FETCH/DECODE/EXEC/WB) control sequencer: fetches, decodes and
// drives registered datapath controls, owns the pc and the retired counter.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [XLEN-1:0]    imem_rdata_i,
  output logic [RA_W-1:0]    read_addr1_o,
  output logic [RA_W-1:0]    read_addr2_o,
  output logic [RA_W-1:0]    write_addr_o,
  output logic [XLEN-1:0]    write_data_o,
  output logic               reg_write_o,
  output logic               reg_read_o,
  output logic [IMM_W-1:0]   instr_o,
  output logic               alu_src1_o,
  output logic               alu_src2_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic               ovf_i,
  input  logic               zero_i,
  output logic               halted_o,
  output logic [ERR_W-1:0]   err_o,
  output logic [XLEN-1:0]    retired_o
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      ir_q, ir_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [XLEN-1:0]      retired_q, retired_d;
  logic                 halted_q, halted_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 imem_req_q, imem_req_d;
  logic                 reg_read_q, reg_read_d;
  logic                 reg_write_q, reg_write_d;
  logic [RA_W-1:0]      wa_q, wa_d;
  logic [ALUOP_W-1:0]   alu_op_q, alu_op_d;
  logic                 src1_q, src1_d;
  logic                 src2_q, src2_d;

  logic [OP_W-1:0]      dec_op;
  logic [ALUOP_W-1:0]   dec_funct;
  ctrl_t                dec;
  logic [PC_W-1:0]      br_off;
  logic                 taken;

  // Decode the incoming word while fetching so controls are registered on the DECODE edge.
  assign dec_op    = (state_q == ST_FETCH) ? imem_rdata_i[31:26] : ir_q[31:26];
  assign dec_funct = (state_q == ST_FETCH) ? imem_rdata_i[2:0]   : ir_q[2:0];

  instr_decode u_decode (
    .op_i     (dec_op),
    .funct_i  (dec_funct),
    .ctrl_c_o (dec)
  );

  assign br_off = PC_W'($signed(ir_q[15:0]));
  assign taken  = dec.is_branch && (zero_i ^ dec.br_ne);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      result_q    <= '0;
      retired_q   <= '0;
      halted_q    <= 1'b0;
      err_q       <= ERR_NONE;
      imem_req_q  <= 1'b0;
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      wa_q        <= '0;
      alu_op_q    <= '0;
      src1_q      <= 1'b0;
      src2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      result_q    <= result_d;
      retired_q   <= retired_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      imem_req_q  <= imem_req_d;
      reg_read_q  <= reg_read_d;
      reg_write_q <= reg_write_d;
      wa_q        <= wa_d;
      alu_op_q    <= alu_op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    result_d    = result_q;
    retired_d   = retired_q;
    halted_d    = halted_q;
    err_d       = err_q;
    reg_write_d = 1'b0;
    wa_d        = wa_q;
    alu_op_d    = alu_op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imem_ack_i) begin
          ir_d     = imem_rdata_i;
          wa_d     = dec.dest_rt ? imem_rdata_i[20:16] : imem_rdata_i[15:11];
          alu_op_d = dec.alu_op;
          src1_d   = dec.src1;
          src2_d   = dec.src2;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.illegal) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          err_d    = ERR_ILLEGAL;
        end else if (dec.halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          err_d    = ERR_NONE;
        end else begin
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result_i;
        // pc, retire count and write strobe commit on the EXEC edge so they are visible in WB.
        if (dec.ovf_chk && ovf_i) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          err_d    = ERR_OVF;
        end else begin
          state_d     = ST_WB;
          reg_write_d = dec.we && (wa_q != '0);
          retired_d   = retired_q + 32'd1;
          pc_d        = pc_q + PC_W'(1) + (taken ? br_off : PC_W'(0));
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    imem_req_d = (state_d == ST_FETCH);
    reg_read_d = (state_d == ST_DECODE) || (state_d == ST_EXEC);
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign read_addr1_o = ir_q[25:21];
  assign read_addr2_o = ir_q[20:16];
  assign write_addr_o = wa_q;
  assign write_data_o = result_q;
  assign reg_write_o  = reg_write_q;
  assign reg_read_o   = reg_read_q;
  assign instr_o      = ir_q[15:0];
  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign alu_op_o     = alu_op_q;
  assign halted_o     = halted_q;
  assign err_o        = err_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: predicted write-back results are queued at
// fetch-ack time and compared in the WB cycle.
module tb_ctrl_sequencer;

  localparam int unsigned PC_W = 8;

  logic            clk;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [4:0]      read_addr1, read_addr2, write_addr;
  logic [31:0]     write_data;
  logic            reg_write, reg_read;
  logic [15:0]     instr;
  logic            alu_src1, alu_src2;
  logic [2:0]      alu_op;
  logic [31:0]     alu_result;
  logic            ovf, zero;
  logic            halted;
  logic [1:0]      err;
  logic [31:0]     retired;

  ctrl_sequencer #(.PC_W(PC_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .read_addr1_o (read_addr1),
    .read_addr2_o (read_addr2),
    .write_addr_o (write_addr),
    .write_data_o (write_data),
    .reg_write_o  (reg_write),
    .reg_read_o   (reg_read),
    .instr_o      (instr),
    .alu_src1_o   (alu_src1),
    .alu_src2_o   (alu_src2),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .ovf_i        (ovf),
    .zero_i       (zero),
    .halted_o     (halted),
    .err_o        (err),
    .retired_o    (retired)
  );

  typedef struct {
    logic            wr;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [PC_W-1:0] pc;
    logic [31:0]     ret;
    logic [2:0]      aluop;
    logic            src2;
  } exp_t;

  exp_t            sb_q[$];
  int              checks   = 0;
  int              failures = 0;
  logic [PC_W-1:0] m_pc;
  logic [31:0]     m_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference behaviour of one non-halting instruction at the model pc.
  function automatic exp_t predict(input logic [31:0] iw, input logic [31:0] res, input logic z);
    exp_t       e;
    logic [5:0] op;
    logic       tk;
    op      = iw[31:26];
    tk      = 1'b0;
    e.wr    = 1'b0;
    e.wa    = 5'd0;
    e.wd    = res;
    e.src2  = 1'b0;
    e.aluop = 3'b000;
    case (op)
      6'b000000: begin e.wa = iw[15:11]; e.aluop = iw[2:0]; end
      6'b001000: begin e.wa = iw[20:16]; e.aluop = 3'b000; e.src2 = 1'b1; end
      6'b001100: begin e.wa = iw[20:16]; e.aluop = 3'b010; e.src2 = 1'b1; end
      6'b001101: begin e.wa = iw[20:16]; e.aluop = 3'b011; e.src2 = 1'b1; end
      6'b000100: begin e.aluop = 3'b001; tk = z; end
      6'b000101: begin e.aluop = 3'b001; tk = ~z; end
      default: ;
    endcase
    if (op == 6'b000000 || op == 6'b001000 || op == 6'b001100 || op == 6'b001101)
      e.wr = (e.wa != 5'd0);
    e.pc  = m_pc + PC_W'(1) + (tk ? PC_W'(iw[PC_W-1:0]) : PC_W'(0));
    e.ret = m_ret + 32'd1;
    return e;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    step();
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_wr", reg_write, 0);
    chk("rst_rd", reg_read, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_retired", retired, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_ctl", {alu_op, alu_src1, alu_src2, instr}, 0);
    rst_n = 1'b1;
    step();
    m_pc  = '0;
    m_ret = '0;
  endtask

  task automatic run_instr(input string name, input logic [31:0] iw, input int waits,
                           input logic [31:0] res, input logic z, output int ncyc);
    exp_t e;
    int   n;
    n = 1;
    chk({name, "_req"}, imem_req, 1);
    chk({name, "_addr"}, imem_addr, 32'(m_pc));
    alu_result = res;
    zero       = z;
    ovf        = 1'b0;
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      step();
      n++;
      chk({name, "_wait_req"}, imem_req, 1);
      chk({name, "_wait_addr"}, imem_addr, 32'(m_pc));
    end
    imem_ack   = 1'b1;
    imem_rdata = iw;
    sb_q.push_back(predict(iw, res, z));
    step();
    n++;
    imem_rdata = $urandom;
    chk({name, "_dec_rd"}, reg_read, 1);
    chk({name, "_dec_req"}, imem_req, 0);
    chk({name, "_dec_wr"}, reg_write, 0);
    chk({name, "_dec_ra1"}, read_addr1, 32'(iw[25:21]));
    chk({name, "_dec_ra2"}, read_addr2, 32'(iw[20:16]));
    chk({name, "_dec_imm"}, instr, 32'(iw[15:0]));
    step();
    n++;
    imem_ack = 1'b0;
    chk({name, "_exe_wr"}, reg_write, 0);
    chk({name, "_exe_rd"}, reg_read, 1);
    step();
    n++;
    e = sb_q.pop_front();
    chk({name, "_wb_wr"}, reg_write, 32'(e.wr));
    if (e.wr) begin
      chk({name, "_wb_wa"}, write_addr, 32'(e.wa));
      chk({name, "_wb_wd"}, write_data, e.wd);
    end
    chk({name, "_wb_pc"}, imem_addr, 32'(e.pc));
    chk({name, "_wb_ret"}, retired, e.ret);
    chk({name, "_wb_aluop"}, alu_op, 32'(e.aluop));
    chk({name, "_wb_src2"}, alu_src2, 32'(e.src2));
    m_pc  = e.pc;
    m_ret = e.ret;
    ncyc  = n;
    step();
    chk({name, "_nxt_wr"}, reg_write, 0);
  endtask

  task automatic run_halt(input string name, input logic [31:0] iw, input logic o,
                          input int stages, input logic [1:0] exp_err);
    chk({name, "_req"}, imem_req, 1);
    alu_result = 32'h8000_0000;
    ovf        = o;
    zero       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = iw;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < stages - 1; i++) begin
      chk({name, "_pre_halted"}, halted, 0);
      chk({name, "_pre_wr"}, reg_write, 0);
      step();
    end
    chk({name, "_halted"}, halted, 1);
    chk({name, "_err"}, err, 32'(exp_err));
    chk({name, "_ret"}, retired, m_ret);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk({name, "_h_req"}, imem_req, 0);
      chk({name, "_h_wr"}, reg_write, 0);
      chk({name, "_h_pc"}, imem_addr, 32'(m_pc));
      chk({name, "_h_ret"}, retired, m_ret);
      chk({name, "_h_sticky"}, halted, 1);
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    int nc;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    alu_result = '0;
    zero       = 1'b0;
    ovf        = 1'b0;
    m_pc       = '0;
    m_ret      = '0;

    do_reset();

    run_instr("addi", {6'b001000, 5'd0, 5'd1, 16'd5}, 0, 32'd5, 1'b0, nc);
    chk("addi_cycles", nc, 4);
    run_instr("sub", {6'b000000, 5'd1, 5'd2, 5'd3, 8'd0, 3'b001}, 0, 32'd0, 1'b1, nc);
    run_instr("or_r0", {6'b000000, 5'd1, 5'd2, 5'd0, 8'd0, 3'b011}, 0, 32'h1234, 1'b0, nc);
    run_instr("ori_wait", {6'b001101, 5'd1, 5'd4, 16'h00F0}, 3, 32'hF5, 1'b0, nc);
    chk("ori_cycles", nc, 7);
    chk("pc_before_beq", imem_addr, 4);
    run_instr("beq_t", {6'b000100, 5'd1, 5'd2, 16'hFFFE}, 0, 32'd0, 1'b1, nc);
    run_instr("bne_nt", {6'b000101, 5'd1, 5'd2, 16'h0007}, 0, 32'd0, 1'b1, nc);
    run_instr("beq_nt", {6'b000100, 5'd1, 5'd2, 16'hFFFE}, 0, 32'd9, 1'b0, nc);
    run_instr("xor", {6'b000000, 5'd5, 5'd6, 5'd7, 8'd0, 3'b100}, 1, 32'hDEAD_BEEF, 1'b0, nc);
    run_instr("slt", {6'b000000, 5'd7, 5'd6, 5'd8, 8'd0, 3'b101}, 2, 32'd1, 1'b0, nc);
    run_instr("andi", {6'b001100, 5'd9, 5'd31, 16'h0F0F}, 0, 32'h0000_0A0A, 1'b0, nc);

    // Reset pulse while in EXEC.
    chk("mid_req", imem_req, 1);
    alu_result = 32'd77;
    imem_ack   = 1'b1;
    imem_rdata = {6'b001000, 5'd0, 5'd2, 16'd77};
    step();
    imem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_pc", imem_addr, 0);
    chk("mid_rst_wr", reg_write, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_ret", retired, 0);
    chk("mid_rst_rd", reg_read, 0);
    rst_n = 1'b1;
    step();
    m_pc  = '0;
    m_ret = '0;

    // pc wrap: branch to 254, then two sequential instructions.
    run_instr("beq_far", {6'b000100, 5'd0, 5'd0, 16'h00FD}, 0, 32'd0, 1'b1, nc);
    chk("far_pc", imem_addr, 254);
    run_instr("addi_254", {6'b001000, 5'd0, 5'd10, 16'd1}, 0, 32'd1, 1'b0, nc);
    run_instr("addi_255", {6'b001000, 5'd0, 5'd11, 16'd2}, 0, 32'd2, 1'b0, nc);
    chk("wrap_pc", imem_addr, 0);

    run_halt("add_ovf", {6'b000000, 5'd1, 5'd1, 5'd2, 8'd0, 3'b000}, 1'b1, 3, 2'b10);

    do_reset();
    run_halt("illegal_op", {6'b010101, 26'h0}, 1'b0, 2, 2'b01);

    do_reset();
    run_instr("and_nochk", {6'b000000, 5'd1, 5'd2, 5'd3, 8'd0, 3'b010}, 0, 32'h55, 1'b0, nc);
    run_halt("bad_funct", {6'b000000, 5'd1, 5'd2, 5'd3, 8'd0, 3'b110}, 1'b0, 2, 2'b01);

    do_reset();
    run_halt("halt_op", {6'b111111, 26'h0}, 1'b0, 2, 2'b00);

    do_reset();
    run_instr("after_rst", {6'b001000, 5'd0, 5'd1, 16'd3}, 0, 32'd3, 1'b0, nc);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
